worm_sequencer: RTL and testbench

- Controller that sequences the 6-position worm display.
- Generates timed advance events, accepts branch-offset requests from the core through a req/ack handshake, and computes the next worm position modulo 6.
- Drives the one-hot worm output directly to the LED bank.

---
 rtl/worm_sequencer.sv | 119 +++++++++++
 tb/tb_worm_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/worm_sequencer.sv
// worm_sequencer: sequences the 6-position worm LED display.
//   Timed advances every STEP_DIV clocks while in RUN, manual single steps
//   in IDLE, and branch offsets accepted over a req/ack handshake that add
//   to the next advance. Position wraps modulo NPOS.
// Ports:
//   clkin        system clock, rising edge
//   reset        asynchronous active-high reset
//   run_en       level, 1 = free-running timed advance
//   step_req     single-cycle manual advance, honoured only in IDLE
//   branch_req   level, branch offset request held until acked
//   branch_off   sign-extended immediate, bits [2:0] used
//   branch_ack   one-cycle acceptance pulse
//   busy         accepted offset pending
//   pos          current position 0..5
//   wrap_pulse   one-cycle pulse when an advance wraps past the last position
//   display_worm one-hot worm, pos 0 = 6'b100000
module worm_sequencer #(
  parameter int unsigned STEP_DIV = 5000000,
  parameter int unsigned DIV_W    = 23,
  parameter int unsigned NPOS     = 6
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       run_en,
  input  logic       step_req,
  input  logic       branch_req,
  input  logic [7:0] branch_off,
  output logic       branch_ack,
  output logic       busy,
  output logic [2:0] pos,
  output logic       wrap_pulse,
  output logic [5:0] display_worm
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div, div_nx;
  logic             tick;
  logic             advance;
  logic             accept;
  logic             armed;
  logic             pending;
  logic [2:0]       off;
  logic [2:0]       off_in;
  logic [3:0]       sum;
  logic             wrap_now;
  logic [2:0]       pos_nx;

  // Upper immediate bits only carry the sign extension.
  logic unused_off_bits;
  assign unused_off_bits = ^branch_off[7:3];

  assign tick    = (state == RUN) && (div == DIV_W'(STEP_DIV - 1));
  assign advance = tick || ((state == IDLE) && step_req);

  // armed drops on acceptance and returns once branch_req has been seen low,
  // so a request still held after its ack cannot be accepted a second time.
  assign accept  = branch_req && !pending && armed;

  assign off_in  = (branch_off[2:0] >= 3'(NPOS)) ? 3'(branch_off[2:0] - 3'(NPOS))
                                                  : branch_off[2:0];

  // Uses only the offset pending before this cycle; a same-cycle acceptance
  // lands in off and applies to the following advance.
  assign sum      = {1'b0, pos} + 4'd1 + (pending ? {1'b0, off} : 4'd0);
  assign wrap_now = (sum >= 4'(NPOS));
  assign pos_nx   = wrap_now ? 3'(sum - 4'(NPOS)) : sum[2:0];

  assign busy         = pending;
  assign display_worm = 6'b100000 >> pos;

  always_comb begin
    state_nx = state;
    div_nx   = '0;
    case (state)
      IDLE: begin
        if (run_en) state_nx = RUN;
      end
      RUN: begin
        if (!run_en)   state_nx = IDLE;
        else if (tick) div_nx   = '0;
        else           div_nx   = div + DIV_W'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div        <= '0;
      pos        <= '0;
      pending    <= 1'b0;
      off        <= '0;
      armed      <= 1'b1;
      branch_ack <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      div        <= div_nx;
      branch_ack <= accept;
      wrap_pulse <= advance && wrap_now;
      if (advance) pos <= pos_nx;
      if (accept) begin
        pending <= 1'b1;
        off     <= off_in;
      end else if (advance) begin
        pending <= 1'b0;
      end
      if (accept)           armed <= 1'b0;
      else if (!branch_req) armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_worm_sequencer.sv
module tb_worm_sequencer;

  localparam int unsigned SD = 4;

  logic       clkin = 1'b0;
  logic       reset;
  logic       run_en;
  logic       step_req;
  logic       branch_req;
  logic [7:0] branch_off;
  logic       branch_ack;
  logic       busy;
  logic [2:0] pos;
  logic       wrap_pulse;
  logic [5:0] display_worm;

  worm_sequencer #(.STEP_DIV(SD), .DIV_W(3), .NPOS(6)) dut (
    .clkin        (clkin),
    .reset        (reset),
    .run_en       (run_en),
    .step_req     (step_req),
    .branch_req   (branch_req),
    .branch_off   (branch_off),
    .branch_ack   (branch_ack),
    .busy         (busy),
    .pos          (pos),
    .wrap_pulse   (wrap_pulse),
    .display_worm (display_worm)
  );

  always #5 clkin = ~clkin;

  int tests = 0;
  int fails = 0;

  // Reference model: running flag plus cycles since the last timed advance.
  int m_pos, m_off, m_cnt;
  bit m_pend, m_run, m_armed, m_ack, m_wrap;

  task automatic model_reset();
    m_pos = 0; m_off = 0; m_cnt = 0;
    m_pend = 0; m_run = 0; m_armed = 1; m_ack = 0; m_wrap = 0;
  endtask

  // Advance the model by one clock from the inputs currently driven, then
  // let the DUT take the same edge and settle.
  task automatic clk1();
    bit adv, acc;
    int s;
    adv = m_run ? (m_cnt == SD - 1) : step_req;
    acc = branch_req && !m_pend && m_armed;
    if (adv) begin
      s      = m_pos + 1 + (m_pend ? m_off : 0);
      m_wrap = (s >= 6);
      m_pos  = s % 6;
    end else begin
      m_wrap = 0;
    end
    if (acc) begin
      m_off  = int'(branch_off[2:0]) % 6;
      m_pend = 1;
    end else if (adv) begin
      m_pend = 0;
    end
    m_ack = acc;
    if (acc) m_armed = 0;
    else if (!branch_req) m_armed = 1;
    if (m_run) begin
      if (!run_en) begin m_run = 0; m_cnt = 0; end
      else m_cnt = (m_cnt + 1) % SD;
    end else if (run_en) begin
      m_run = 1; m_cnt = 0;
    end
    @(posedge clkin);
    #1;
  endtask

  task automatic do_reset();
    run_en = 0; step_req = 0; branch_req = 0; branch_off = '0;
    reset = 1;
    @(posedge clkin);
    #1 reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    run_en = 0; step_req = 0; branch_req = 0; branch_off = '0;
    reset = 1;
    #2;
    tests++; if (pos !== 3'd0) begin fails++; $display("FAIL reset_pos_async: got %0d want 0", pos); end
    @(posedge clkin); #1;
    tests++; if (pos !== 3'd0) begin fails++; $display("FAIL reset_pos: got %0d want 0", pos); end
    tests++; if (display_worm !== 6'b100000) begin fails++; $display("FAIL reset_display: got %b want 100000", display_worm); end
    tests++; if (busy !== 1'b0 || branch_ack !== 1'b0 || wrap_pulse !== 1'b0) begin
      fails++; $display("FAIL reset_flags: busy=%b ack=%b wrap=%b want 0 0 0", busy, branch_ack, wrap_pulse);
    end
    reset = 0;
    model_reset();
  endtask

  task automatic test_step_wrap();
    int exp_seq[7] = '{1, 2, 3, 4, 5, 0, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step_req = 1;
      clk1();
      step_req = 0;
      tests++; if (pos !== 3'(exp_seq[i])) begin fails++; $display("FAIL step_pos[%0d]: got %0d want %0d", i, pos, exp_seq[i]); end
      tests++; if (wrap_pulse !== (i == 5)) begin fails++; $display("FAIL step_wrap[%0d]: got %b want %b", i, wrap_pulse, (i == 5)); end
      clk1();
      tests++; if (wrap_pulse !== 1'b0) begin fails++; $display("FAIL step_wrap_gap[%0d]: got %b want 0", i, wrap_pulse); end
    end
    tests++; if (display_worm !== 6'b010000) begin fails++; $display("FAIL step_display: got %b want 010000", display_worm); end
  endtask

  task automatic test_run_timing();
    int n;
    int exp_n;
    logic [2:0] p0;
    do_reset();
    run_en = 1;
    for (int k = 0; k < 4; k++) begin
      p0 = pos; n = 0;
      do begin clk1(); n++; end while (pos === p0 && n < 20);
      // first change: the edge that enters RUN plus STEP_DIV counting cycles
      exp_n = (k == 0) ? SD + 1 : SD;
      tests++; if (n != exp_n) begin fails++; $display("FAIL run_interval[%0d]: got %0d cycles want %0d", k, n, exp_n); end
      tests++; if (pos !== 3'(k + 1)) begin fails++; $display("FAIL run_pos[%0d]: got %0d want %0d", k, pos, k + 1); end
    end
    clk1(); clk1();
    run_en = 0;
    for (int k = 0; k < 6; k++) begin
      clk1();
      tests++; if (pos !== 3'd4) begin fails++; $display("FAIL run_frozen[%0d]: got %0d want 4", k, pos); end
    end
    run_en = 1;
    n = 0;
    do begin clk1(); n++; end while (pos === 3'd4 && n < 20);
    tests++; if (n != SD + 1) begin fails++; $display("FAIL run_reentry: got %0d cycles want %0d", n, SD + 1); end
    tests++; if (pos !== 3'd5) begin fails++; $display("FAIL run_reentry_pos: got %0d want 5", pos); end
    run_en = 0;
    clk1();
  endtask

  task automatic test_branch();
    do_reset();
    step_req = 1;
    repeat (3) clk1();
    step_req = 0;
    branch_req = 1; branch_off = 8'h02;
    clk1();
    tests++; if (branch_ack !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL branch_ack: ack=%b busy=%b want 1 1", branch_ack, busy);
    end
    branch_req = 0;
    clk1();
    tests++; if (branch_ack !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL branch_ack_once: ack=%b busy=%b want 0 1", branch_ack, busy);
    end
    step_req = 1;
    clk1();
    step_req = 0;
    tests++; if (pos !== 3'd0 || wrap_pulse !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL branch_apply: pos=%0d wrap=%b busy=%b want 0 1 0", pos, wrap_pulse, busy);
    end
  endtask

  task automatic test_branch_hold();
    int acks;
    do_reset();
    step_req = 1;
    repeat (4) clk1();
    step_req = 0;
    branch_req = 1; branch_off = 8'hFF;
    clk1();
    tests++; if (branch_ack !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL hold_first_ack: ack=%b busy=%b want 1 1", branch_ack, busy);
    end
    acks = 0;
    repeat (5) begin clk1(); if (branch_ack === 1'b1) acks++; end
    tests++; if (acks != 0) begin fails++; $display("FAIL hold_no_reack: got %0d acks want 0", acks); end
    step_req = 1;
    clk1();
    step_req = 0;
    tests++; if (pos !== 3'd0 || wrap_pulse !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL hold_apply: pos=%0d wrap=%b busy=%b want 0 1 0", pos, wrap_pulse, busy);
    end
    acks = 0;
    repeat (3) begin clk1(); if (branch_ack === 1'b1) acks++; end
    tests++; if (acks != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL hold_edge_qual: acks=%0d busy=%b want 0 0", acks, busy);
    end
    branch_req = 0;
    clk1();
    branch_req = 1;
    clk1();
    tests++; if (branch_ack !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL hold_second_ack: ack=%b busy=%b want 1 1", branch_ack, busy);
    end
    branch_req = 0;
    clk1();
  endtask

  task automatic test_accept_on_tick();
    do_reset();
    run_en = 1;
    repeat (4) clk1();
    branch_req = 1; branch_off = 8'h03;
    clk1();
    branch_req = 0;
    tests++; if (pos !== 3'd1 || branch_ack !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL tick_accept: pos=%0d ack=%b busy=%b want 1 1 1", pos, branch_ack, busy);
    end
    repeat (3) clk1();
    tests++; if (pos !== 3'd1) begin fails++; $display("FAIL tick_wait: got %0d want 1", pos); end
    clk1();
    tests++; if (pos !== 3'd5 || busy !== 1'b0 || wrap_pulse !== 1'b0) begin
      fails++; $display("FAIL tick_apply: pos=%0d busy=%b wrap=%b want 5 0 0", pos, busy, wrap_pulse);
    end
    run_en = 0;
    clk1();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    run_en = 1;
    repeat (6) clk1();
    branch_req = 1; branch_off = 8'h02;
    clk1();
    branch_req = 0;
    clk1();
    tests++; if (busy !== 1'b1 || pos !== 3'd1) begin
      fails++; $display("FAIL midrst_setup: busy=%b pos=%0d want 1 1", busy, pos);
    end
    branch_req = 1;
    #3 reset = 1;
    #1;
    tests++; if (pos !== 3'd0 || display_worm !== 6'b100000 || busy !== 1'b0 || branch_ack !== 1'b0) begin
      fails++; $display("FAIL midrst_clear: pos=%0d disp=%b busy=%b ack=%b want 0 100000 0 0", pos, display_worm, busy, branch_ack);
    end
    branch_req = 0;
    @(posedge clkin);
    #1 reset = 0;
    model_reset();
    tests++; if (branch_ack !== 1'b0) begin fails++; $display("FAIL midrst_no_ack: got %b want 0", branch_ack); end
    step_req = 1;
    clk1();
    tests++; if (pos !== 3'd1) begin fails++; $display("FAIL midrst_idle_step: got %0d want 1", pos); end
    clk1();
    step_req = 0;
    tests++; if (pos !== 3'd1 || branch_ack !== 1'b0) begin
      fails++; $display("FAIL midrst_run_ignores_step: pos=%0d ack=%b want 1 0", pos, branch_ack);
    end
    run_en = 0;
    clk1();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) run_en = ~run_en;
      step_req = ($urandom_range(9) < 3);
      if (!branch_req && $urandom_range(4) == 0) begin
        branch_req = 1;
        branch_off = 8'($urandom);
      end
      clk1();
      if (m_ack && $urandom_range(3) != 0) branch_req = 0;
      tests++; if (pos !== 3'(m_pos)) begin fails++; $display("FAIL rnd_pos[%0d]: got %0d want %0d", i, pos, m_pos); end
      tests++; if (display_worm !== 6'(1 << (5 - m_pos))) begin
        fails++; $display("FAIL rnd_display[%0d]: got %b want pos %0d", i, display_worm, m_pos);
      end
      tests++; if (busy !== m_pend) begin fails++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_pend); end
      tests++; if (branch_ack !== m_ack) begin fails++; $display("FAIL rnd_ack[%0d]: got %b want %b", i, branch_ack, m_ack); end
      tests++; if (wrap_pulse !== m_wrap) begin fails++; $display("FAIL rnd_wrap[%0d]: got %b want %b", i, wrap_pulse, m_wrap); end
    end
  endtask

  initial begin
    test_reset();
    test_step_wrap();
    test_run_timing();
    test_branch();
    test_branch_hold();
    test_accept_on_tick();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
